// File: rtl/linreg_stream.sv
// -----------------------------------------------------------------------------
// linreg_stream
//
// Streaming least-squares line fit. Sample pairs (x, y) are accumulated into
// n, Sx, Sy, Sxx and Sxy. When a batch closes (in_last, or MAX_SAMPLES
// accepted), the block forms
//     det = n*Sxx - Sx*Sx
//     Ns  = n*Sxy - Sx*Sy        slope     = Ns / det
//     Ni  = Sxx*Sy - Sx*Sxy      intercept = Ni / det
// and runs both quotients through a single shared sequential restoring
// divider. Quotients are truncated toward zero and saturated to RES_W bits.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   in_valid/in_ready  sample handshake; in_x, in_y signed samples, in_last
//                      marks the final sample of a batch
//   out_valid/out_ready result handshake
//   slope, intercept   signed RES_W results
//   det                signed batch determinant (PROD_W bits)
//   n_samples          number of samples in the batch
//   err_singular       det was zero (slope = intercept = 0)
//   err_sat            at least one quotient was clipped to the RES_W range
// -----------------------------------------------------------------------------
module linreg_stream #(
    parameter int  DATA_W      = 8,
    parameter int  MAX_SAMPLES = 16,
    parameter int  RES_W       = 16,
    localparam int CNT_W       = $clog2(MAX_SAMPLES + 1),
    localparam int ACC_W       = 2 * DATA_W + CNT_W + 1,
    localparam int PROD_W      = 2 * ACC_W + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_x,
    input  logic signed [DATA_W-1:0] in_y,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [RES_W-1:0]  slope,
    output logic signed [RES_W-1:0]  intercept,
    output logic signed [PROD_W-1:0] det,
    output logic [CNT_W-1:0]         n_samples,
    output logic                     err_singular,
    output logic                     err_sat
);

    localparam int SQ_W   = 2 * DATA_W;
    localparam int DIV_CW = $clog2(PROD_W + 1);

    // Largest positive / most negative result magnitudes, widened to PROD_W
    localparam logic [PROD_W-1:0] POS_LIM = {{(PROD_W - RES_W + 1){1'b0}}, {(RES_W - 1){1'b1}}};
    localparam logic [PROD_W-1:0] NEG_LIM = POS_LIM + 1'b1;

    typedef enum logic [2:0] {
        ST_ACCUM,
        ST_PREP,
        ST_DIV_S,
        ST_DIV_I,
        ST_OUT
    } state_t;

    state_t state_reg, state_next;

    // Input stage: squares/cross products are registered at accept time and
    // added into the accumulators one cycle later, keeping the multiplier and
    // the wide adder in separate cycles.
    logic                     stg_valid_reg;
    logic signed [DATA_W-1:0] stg_x_reg, stg_y_reg;
    logic signed [SQ_W-1:0]   stg_xx_reg, stg_xy_reg;
    logic                     close_reg;   // closing sample sits in the stage

    logic [CNT_W-1:0]         n_reg;
    logic signed [ACC_W-1:0]  sx_reg, sy_reg, sxx_reg, sxy_reg;

    // Divider working state
    logic signed [PROD_W-1:0] det_val_reg;
    logic [PROD_W-1:0]        det_mag_reg, ni_mag_reg;
    logic                     neg_s_reg, neg_i_reg;
    logic [PROD_W:0]          rem_reg;
    logic [PROD_W-1:0]        quo_reg;
    logic [DIV_CW-1:0]        cnt_reg;
    logic signed [RES_W-1:0]  slope_work_reg;
    logic                     sat_work_reg;

    // Presented result registers
    logic signed [RES_W-1:0]  slope_reg, intercept_reg;
    logic signed [PROD_W-1:0] det_reg;
    logic [CNT_W-1:0]         n_out_reg;
    logic                     err_singular_reg, err_sat_reg;

    // -------------------------------------------------------------------------
    // Input products and batch-close detection
    // -------------------------------------------------------------------------
    logic signed [SQ_W-1:0] x_w, y_w, xx_w, xy_w;
    logic                   accept, closing;

    assign x_w     = SQ_W'(in_x);
    assign y_w     = SQ_W'(in_y);
    assign xx_w    = x_w * x_w;
    assign xy_w    = x_w * y_w;
    assign accept  = in_valid && in_ready;
    assign closing = accept && (in_last || (n_reg == CNT_W'(MAX_SAMPLES - 1)));

    // -------------------------------------------------------------------------
    // Batch products: index 0 = det, 1 = Ns, 2 = Ni
    // -------------------------------------------------------------------------
    logic signed [PROD_W-1:0] n_e, sx_e, sy_e, sxx_e, sxy_e;
    logic signed [PROD_W-1:0] prep_val [3];
    logic [PROD_W-1:0]        prep_mag [3];
    logic                     prep_neg [3];
    logic                     det_zero;

    assign n_e   = $signed(PROD_W'(n_reg));
    assign sx_e  = PROD_W'(sx_reg);
    assign sy_e  = PROD_W'(sy_reg);
    assign sxx_e = PROD_W'(sxx_reg);
    assign sxy_e = PROD_W'(sxy_reg);

    assign prep_val[0] = n_e * sxx_e - sx_e * sx_e;
    assign prep_val[1] = n_e * sxy_e - sx_e * sy_e;
    assign prep_val[2] = sxx_e * sy_e - sx_e * sxy_e;
    assign det_zero    = (prep_val[0] == '0);

    // The divider works on magnitudes; signs are recombined afterwards
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_mag
            assign prep_neg[gi] = prep_val[gi][PROD_W-1];
            assign prep_mag[gi] = prep_neg[gi] ? $unsigned(-prep_val[gi])
                                               : $unsigned(prep_val[gi]);
        end
    endgenerate

    // -------------------------------------------------------------------------
    // One restoring-divide step and result saturation
    // -------------------------------------------------------------------------
    logic [PROD_W:0]   rem_shift, rem_step;
    logic [PROD_W-1:0] quo_step;
    logic [RES_W:0]    sat_word;   // {saturated, result}
    logic              div_last;

    function automatic logic [RES_W:0] saturate(input logic [PROD_W-1:0] mag,
                                                input logic              neg);
        logic [PROD_W-1:0] neg_mag;
        logic [RES_W:0]    res;
        neg_mag = ~mag + 1'b1;
        if (neg) begin
            if (mag > NEG_LIM) res = {1'b1, 1'b1, {(RES_W - 1){1'b0}}};
            else               res = {1'b0, neg_mag[RES_W-1:0]};
        end else begin
            if (mag > POS_LIM) res = {1'b1, 1'b0, {(RES_W - 1){1'b1}}};
            else               res = {1'b0, mag[RES_W-1:0]};
        end
        return res;
    endfunction

    always_comb begin
        rem_shift = {rem_reg[PROD_W-1:0], quo_reg[PROD_W-1]};
        rem_step  = rem_shift;
        quo_step  = {quo_reg[PROD_W-2:0], 1'b0};
        if (rem_shift >= {1'b0, det_mag_reg}) begin
            rem_step = rem_shift - {1'b0, det_mag_reg};
            quo_step = {quo_reg[PROD_W-2:0], 1'b1};
        end
        sat_word = saturate(quo_step, (state_reg == ST_DIV_I) ? neg_i_reg : neg_s_reg);
        div_last = (cnt_reg == DIV_CW'(PROD_W - 1));
    end

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= ST_ACCUM;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            ST_ACCUM: begin
                // Hold off new samples while the closing one drains the stage
                in_ready = !close_reg;
                if (close_reg) state_next = ST_PREP;
            end
            ST_PREP:  state_next = det_zero ? ST_OUT : ST_DIV_S;
            ST_DIV_S: if (div_last) state_next = ST_DIV_I;
            ST_DIV_I: if (div_last) state_next = ST_OUT;
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_next = ST_ACCUM;
            end
            default:  state_next = ST_ACCUM;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_valid_reg    <= 1'b0;
            stg_x_reg        <= '0;
            stg_y_reg        <= '0;
            stg_xx_reg       <= '0;
            stg_xy_reg       <= '0;
            close_reg        <= 1'b0;
            n_reg            <= '0;
            sx_reg           <= '0;
            sy_reg           <= '0;
            sxx_reg          <= '0;
            sxy_reg          <= '0;
            det_val_reg      <= '0;
            det_mag_reg      <= '0;
            ni_mag_reg       <= '0;
            neg_s_reg        <= 1'b0;
            neg_i_reg        <= 1'b0;
            rem_reg          <= '0;
            quo_reg          <= '0;
            cnt_reg          <= '0;
            slope_work_reg   <= '0;
            sat_work_reg     <= 1'b0;
            slope_reg        <= '0;
            intercept_reg    <= '0;
            det_reg          <= '0;
            n_out_reg        <= '0;
            err_singular_reg <= 1'b0;
            err_sat_reg      <= 1'b0;
        end else begin
            case (state_reg)
                ST_ACCUM: begin
                    stg_valid_reg <= accept;
                    if (accept) begin
                        n_reg      <= n_reg + 1'b1;
                        stg_x_reg  <= in_x;
                        stg_y_reg  <= in_y;
                        stg_xx_reg <= xx_w;
                        stg_xy_reg <= xy_w;
                    end
                    if (stg_valid_reg) begin
                        sx_reg  <= sx_reg  + ACC_W'(stg_x_reg);
                        sy_reg  <= sy_reg  + ACC_W'(stg_y_reg);
                        sxx_reg <= sxx_reg + ACC_W'(stg_xx_reg);
                        sxy_reg <= sxy_reg + ACC_W'(stg_xy_reg);
                    end
                    // closing and close_reg are mutually exclusive (in_ready=0)
                    close_reg <= closing;
                end
                ST_PREP: begin
                    det_val_reg  <= prep_val[0];
                    det_mag_reg  <= prep_mag[0];
                    ni_mag_reg   <= prep_mag[2];
                    neg_s_reg    <= prep_neg[1] ^ prep_neg[0];
                    neg_i_reg    <= prep_neg[2] ^ prep_neg[0];
                    rem_reg      <= '0;
                    quo_reg      <= prep_mag[1];
                    cnt_reg      <= '0;
                    sat_work_reg <= 1'b0;
                    if (det_zero) begin
                        slope_reg        <= '0;
                        intercept_reg    <= '0;
                        det_reg          <= prep_val[0];
                        n_out_reg        <= n_reg;
                        err_singular_reg <= 1'b1;
                        err_sat_reg      <= 1'b0;
                    end
                end
                ST_DIV_S: begin
                    rem_reg <= rem_step;
                    quo_reg <= quo_step;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (div_last) begin
                        // Slope done: park it and reload the divider for Ni
                        slope_work_reg <= sat_word[RES_W-1:0];
                        sat_work_reg   <= sat_word[RES_W];
                        rem_reg        <= '0;
                        quo_reg        <= ni_mag_reg;
                        cnt_reg        <= '0;
                    end
                end
                ST_DIV_I: begin
                    rem_reg <= rem_step;
                    quo_reg <= quo_step;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (div_last) begin
                        slope_reg        <= slope_work_reg;
                        intercept_reg    <= sat_word[RES_W-1:0];
                        det_reg          <= det_val_reg;
                        n_out_reg        <= n_reg;
                        err_singular_reg <= 1'b0;
                        err_sat_reg      <= sat_work_reg | sat_word[RES_W];
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        n_reg   <= '0;
                        sx_reg  <= '0;
                        sy_reg  <= '0;
                        sxx_reg <= '0;
                        sxy_reg <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign slope        = slope_reg;
    assign intercept    = intercept_reg;
    assign det          = det_reg;
    assign n_samples    = n_out_reg;
    assign err_singular = err_singular_reg;
    assign err_sat      = err_sat_reg;

endmodule

// File: tb/tb_linreg_stream.sv
// -----------------------------------------------------------------------------
// tb_linreg_stream
//
// Directed bench for linreg_stream. Instance a uses default parameters,
// instance b uses RES_W=8 and MAX_SAMPLES=4. Inputs change and outputs are
// sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_linreg_stream;

    localparam int A_CNT_W  = $clog2(16 + 1);
    localparam int A_PROD_W = 2 * (16 + A_CNT_W + 1) + 1;   // 45
    localparam int B_CNT_W  = $clog2(4 + 1);
    localparam int B_PROD_W = 2 * (16 + B_CNT_W + 1) + 1;   // 41
    localparam int A_LAT    = 2 * A_PROD_W + 2;
    localparam int B_LAT    = 2 * B_PROD_W + 2;

    logic clk;
    logic rst;

    logic                      a_in_valid, a_in_ready, a_in_last;
    logic signed [7:0]         a_in_x, a_in_y;
    logic                      a_out_valid, a_out_ready;
    logic signed [15:0]        a_slope, a_intercept;
    logic signed [A_PROD_W-1:0] a_det;
    logic [A_CNT_W-1:0]        a_n_samples;
    logic                      a_err_singular, a_err_sat;

    logic                      b_in_valid, b_in_ready, b_in_last;
    logic signed [7:0]         b_in_x, b_in_y;
    logic                      b_out_valid, b_out_ready;
    logic signed [7:0]         b_slope, b_intercept;
    logic signed [B_PROD_W-1:0] b_det;
    logic [B_CNT_W-1:0]        b_n_samples;
    logic                      b_err_singular, b_err_sat;

    int cmp_cnt = 0;
    int err_cnt = 0;

    linreg_stream dut_a (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (a_in_valid),
        .in_ready     (a_in_ready),
        .in_x         (a_in_x),
        .in_y         (a_in_y),
        .in_last      (a_in_last),
        .out_valid    (a_out_valid),
        .out_ready    (a_out_ready),
        .slope        (a_slope),
        .intercept    (a_intercept),
        .det          (a_det),
        .n_samples    (a_n_samples),
        .err_singular (a_err_singular),
        .err_sat      (a_err_sat)
    );

    linreg_stream #(.DATA_W(8), .MAX_SAMPLES(4), .RES_W(8)) dut_b (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (b_in_valid),
        .in_ready     (b_in_ready),
        .in_x         (b_in_x),
        .in_y         (b_in_y),
        .in_last      (b_in_last),
        .out_valid    (b_out_valid),
        .out_ready    (b_out_ready),
        .slope        (b_slope),
        .intercept    (b_intercept),
        .det          (b_det),
        .n_samples    (b_n_samples),
        .err_singular (b_err_singular),
        .err_sat      (b_err_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Offer one sample to instance a; it must be accepted on the next edge
    task automatic push_a(input int x, input int y, input bit last);
        chk("a_in_ready_on_push", a_in_ready, 1);
        a_in_valid = 1'b1;
        a_in_x     = 8'(x);
        a_in_y     = 8'(y);
        a_in_last  = last;
        @(negedge clk);
        a_in_valid = 1'b0;
        a_in_last  = 1'b0;
    endtask

    task automatic push_b(input int x, input int y, input bit last);
        chk("b_in_ready_on_push", b_in_ready, 1);
        b_in_valid = 1'b1;
        b_in_x     = 8'(x);
        b_in_y     = 8'(y);
        b_in_last  = last;
        @(negedge clk);
        b_in_valid = 1'b0;
        b_in_last  = 1'b0;
    endtask

    // Called at the falling edge just after the closing accept; the count
    // returned equals the number of rising edges until out_valid is seen.
    task automatic wait_out_a(output int lat);
        lat = 0;
        while (a_out_valid !== 1'b1 && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic wait_out_b(output int lat);
        lat = 0;
        while (b_out_valid !== 1'b1 && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic handshake_a;
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
        chk("a_out_valid_after_hs", a_out_valid, 0);
        chk("a_in_ready_after_hs", a_in_ready, 1);
    endtask

    task automatic handshake_b;
        b_out_ready = 1'b1;
        @(negedge clk);
        b_out_ready = 1'b0;
        chk("b_out_valid_after_hs", b_out_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit seen;

        rst         = 1'b1;
        a_in_valid  = 1'b0; a_in_last = 1'b0; a_in_x = '0; a_in_y = '0; a_out_ready = 1'b0;
        b_in_valid  = 1'b0; b_in_last = 1'b0; b_in_x = '0; b_in_y = '0; b_out_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_slope", a_slope, 0);
        chk("rst_intercept", a_intercept, 0);
        chk("rst_det", a_det, 0);
        chk("rst_n_samples", a_n_samples, 0);
        chk("rst_err_singular", a_err_singular, 0);
        chk("rst_err_sat", a_err_sat, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", a_in_ready, 1);

        // y = 2x + 1
        push_a(1, 3, 0);
        push_a(2, 5, 0);
        push_a(3, 7, 1);
        chk("b1_in_ready_closing", a_in_ready, 0);
        wait_out_a(lat);
        chk("b1_latency", lat, A_LAT);
        chk("b1_det", a_det, 6);
        chk("b1_slope", a_slope, 2);
        chk("b1_intercept", a_intercept, 1);
        chk("b1_n_samples", a_n_samples, 3);
        chk("b1_err_singular", a_err_singular, 0);
        chk("b1_err_sat", a_err_sat, 0);
        // Back-pressure: result held with out_ready low
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_out_valid", a_out_valid, 1);
            chk("hold_slope", a_slope, 2);
            chk("hold_intercept", a_intercept, 1);
            chk("hold_in_ready", a_in_ready, 0);
        end
        handshake_a();
        chk("b1_slope_retained", a_slope, 2);
        chk("b1_n_retained", a_n_samples, 3);

        // in_last without in_valid is ignored
        a_in_last = 1'b1;
        @(negedge clk);
        a_in_last = 1'b0;
        chk("stray_last_in_ready", a_in_ready, 1);
        @(negedge clk);
        chk("stray_last_out_valid", a_out_valid, 0);

        // y = -2x + 2
        push_a(-1, 4, 0);
        push_a(0, 2, 0);
        push_a(1, 0, 1);
        wait_out_a(lat);
        chk("b2_latency", lat, A_LAT);
        chk("b2_det", a_det, 6);
        chk("b2_slope", a_slope, -2);
        chk("b2_intercept", a_intercept, 2);
        chk("b2_n_samples", a_n_samples, 3);
        handshake_a();

        // Fractional results truncate toward zero (-0.5, -1/6)
        push_a(0, 0, 0);
        push_a(1, -1, 0);
        push_a(2, -1, 1);
        wait_out_a(lat);
        chk("b3_det", a_det, 6);
        chk("b3_slope", a_slope, 0);
        chk("b3_intercept", a_intercept, 0);
        chk("b3_err_sat", a_err_sat, 0);
        handshake_a();

        // Vertical line: singular
        push_a(2, 1, 0);
        push_a(2, 5, 0);
        push_a(2, 9, 1);
        wait_out_a(lat);
        chk("sing_latency", lat, 2);
        chk("sing_det", a_det, 0);
        chk("sing_err_singular", a_err_singular, 1);
        chk("sing_slope", a_slope, 0);
        chk("sing_intercept", a_intercept, 0);
        chk("sing_err_sat", a_err_sat, 0);
        handshake_a();

        // Single-sample batch is singular
        push_a(5, 7, 1);
        wait_out_a(lat);
        chk("one_latency", lat, 2);
        chk("one_err_singular", a_err_singular, 1);
        chk("one_n_samples", a_n_samples, 1);
        handshake_a();

        // Reset during DIV_S aborts the batch
        push_a(4, 4, 0);
        push_a(6, 1, 1);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_n_samples", a_n_samples, 0);
        chk("abort_in_ready", a_in_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 2 * A_LAT; i++) begin
            @(negedge clk);
            if (a_out_valid) seen = 1'b1;
        end
        chk("abort_no_out_valid", seen, 0);
        push_a(1, 3, 0);
        push_a(2, 5, 0);
        push_a(3, 7, 1);
        wait_out_a(lat);
        chk("post_abort_slope", a_slope, 2);
        chk("post_abort_intercept", a_intercept, 1);
        chk("post_abort_n_samples", a_n_samples, 3);
        handshake_a();

        // RES_W=8: slope 255 clips to 127, intercept -128 fits exactly
        push_b(0, -128, 0);
        push_b(1, 127, 1);
        wait_out_b(lat);
        chk("sat_latency", lat, B_LAT);
        chk("sat_det", b_det, 1);
        chk("sat_slope", b_slope, 127);
        chk("sat_intercept", b_intercept, -128);
        chk("sat_err_sat", b_err_sat, 1);
        chk("sat_err_singular", b_err_singular, 0);
        handshake_b();

        // MAX_SAMPLES=4 closes the batch without in_last; 5th offer stalls
        push_b(1, 1, 0);
        push_b(2, 2, 0);
        push_b(3, 3, 0);
        push_b(4, 4, 0);
        b_in_valid = 1'b1;
        b_in_x     = 8'sd5;
        b_in_y     = 8'sd5;
        chk("max_in_ready_5th", b_in_ready, 0);
        wait_out_b(lat);
        b_in_valid = 1'b0;
        chk("max_latency", lat, B_LAT);
        chk("max_n_samples", b_n_samples, 4);
        chk("max_det", b_det, 20);
        chk("max_slope", b_slope, 1);
        chk("max_intercept", b_intercept, 0);
        chk("max_err_sat", b_err_sat, 0);
        handshake_b();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
